// File: rtl/rll_key_sequencer.sv
// Serial key loader for an RLL-locked netlist: shifts a key in LSB first and only
// exposes it on key_out once complete. Optional parity check: RLL_KEY_SEQUENCER_PARITY_EN.
module rll_key_sequencer #(
    parameter int unsigned KEY_WIDTH   = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 key_sdata,
    input  logic                 key_svalid,
    output logic                 key_sready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_armed,
    output logic                 busy,
    output logic                 err
);

`ifdef RLL_KEY_SEQUENCER_PARITY_EN
    localparam int unsigned NBITS = KEY_WIDTH + 1;
`else
    localparam int unsigned NBITS = KEY_WIDTH;
`endif
    localparam int unsigned CNT_W   = $clog2(NBITS + 1);
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StArmed,
        StError
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [NBITS-1:0]     shift_q, shift_d;
    logic [KEY_WIDTH-1:0] key_out_q, key_out_d;

    logic transfer;
    logic last_bit;

    assign key_sready = (state_q == StLoad);
    assign busy       = (state_q == StLoad) || (state_q == StCheck);
    assign err        = (state_q == StError);
    assign key_armed  = (state_q == StArmed);
    assign key_out    = key_out_q;

    // A bit offered alongside clear is dropped.
    assign transfer = key_svalid && key_sready && !clear;
    assign last_bit = (cnt_q == CNT_W'(NBITS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = stall_q;
        shift_d = shift_q;

        unique case (state_q)
            StIdle: begin
                if (!clear && start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (clear) begin
                    state_d = StIdle;
                end else if (transfer) begin
                    for (int unsigned i = 0; i < NBITS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shift_d[i] = key_sdata;
                        end
                    end
                    cnt_d   = cnt_q + CNT_W'(1);
                    stall_d = '0;
                    if (last_bit) begin
`ifdef RLL_KEY_SEQUENCER_PARITY_EN
                        state_d = StCheck;
`else
                        state_d = StArmed;
`endif
                    end
                end else if (stall_q == STALL_W'(TIMEOUT_CYC)) begin
                    state_d = StError;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            StCheck: begin
                if (clear) begin
                    state_d = StIdle;
                end else begin
`ifdef RLL_KEY_SEQUENCER_PARITY_EN
                    state_d = (^shift_q) ? StError : StArmed;
`else
                    state_d = StIdle;
`endif
                end
            end
            StArmed: begin
                if (clear) begin
                    state_d = StIdle;
                end
            end
            StError: begin
                if (clear) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // IDLE always holds an empty shift register and zeroed counters.
        if (state_d == StIdle) begin
            cnt_d   = '0;
            stall_d = '0;
            shift_d = '0;
        end

        key_out_d = '0;
        if (state_d == StArmed) begin
            key_out_d = (state_q == StArmed) ? key_out_q : shift_d[KEY_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            stall_q   <= '0;
            shift_q   <= '0;
            key_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            shift_q   <= shift_d;
            key_out_q <= key_out_d;
        end
    end

endmodule

// File: tb/tb_rll_key_sequencer.sv
// Directed bench for rll_key_sequencer: table of full loads plus hand-written
// sequences for abort, timeout, slow feed, async reset and priority corners.
module tb_rll_key_sequencer;

`ifdef RLL_KEY_SEQUENCER_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic        key_sdata;
    logic        key_svalid;
    logic        key_sready;
    logic [15:0] key_out;
    logic        key_armed;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [15:0] key;
        int          gap;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    rll_key_sequencer #(
        .KEY_WIDTH  (16),
        .TIMEOUT_CYC(255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .key_sdata (key_sdata),
        .key_svalid(key_svalid),
        .key_sready(key_sready),
        .key_out   (key_out),
        .key_armed (key_armed),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, " busy"}, {31'd0, busy}, 32'd0);
        check({name, " armed"}, {31'd0, key_armed}, 32'd0);
        check({name, " key_out"}, {16'd0, key_out}, 32'd0);
        check({name, " sready"}, {31'd0, key_sready}, 32'd0);
        check({name, " err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drive n bits LSB first, with gap idle cycles before each bit.
    task automatic shift_bits(input logic [16:0] bits, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            key_svalid = 1'b0;
            repeat (gap) step();
            key_svalid = 1'b1;
            key_sdata  = bits[i];
            check("load key_out", {16'd0, key_out}, 32'd0);
            check("load sready", {31'd0, key_sready}, 32'd1);
            step();
        end
        key_svalid = 1'b0;
        key_sdata  = 1'b0;
    endtask

    // Start, load key (+ parity in parity builds), stop at the first ARMED/ERROR cycle.
    task automatic load_key(input logic [15:0] key, input int gap, input logic par);
        pulse_start();
        check("start busy", {31'd0, busy}, 32'd1);
        shift_bits({par, key}, NB, gap);
`ifdef RLL_KEY_SEQUENCER_PARITY_EN
        check("check busy", {31'd0, busy}, 32'd1);
        check("check armed", {31'd0, key_armed}, 32'd0);
        check("check key_out", {16'd0, key_out}, 32'd0);
        step();
`endif
    endtask

    initial begin
        logic saw_err;

        vecs[0] = '{key: 16'hA5C3, gap: 0, exp_out: 16'hA5C3};
        vecs[1] = '{key: 16'h1234, gap: 0, exp_out: 16'h1234};
        vecs[2] = '{key: 16'hFFFF, gap: 1, exp_out: 16'hFFFF};
        vecs[3] = '{key: 16'h0000, gap: 0, exp_out: 16'h0000};
        vecs[4] = '{key: 16'h8001, gap: 2, exp_out: 16'h8001};
        vecs[5] = '{key: 16'h5A3C, gap: 0, exp_out: 16'h5A3C};

        rst_n      = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
        key_sdata  = 1'b0;
        key_svalid = 1'b0;
        #3;
        check_idle("reset");
        #9 rst_n = 1'b1;
        step();
        check_idle("post reset");

        for (int v = 0; v < 6; v++) begin
            load_key(vecs[v].key, vecs[v].gap, ^vecs[v].key);
            check("table armed", {31'd0, key_armed}, 32'd1);
            check("table key_out", {16'd0, key_out}, {16'd0, vecs[v].exp_out});
            check("table busy", {31'd0, busy}, 32'd0);
            check("table sready", {31'd0, key_sready}, 32'd0);
            clear = 1'b1;
            step();
            clear = 1'b0;
            check_idle("table clear");
        end

        // Abort after 8 bits; the bit offered with clear is dropped.
        pulse_start();
        shift_bits(17'h000FF, 8, 0);
        key_svalid = 1'b1;
        key_sdata  = 1'b1;
        clear      = 1'b1;
        step();
        clear      = 1'b0;
        key_svalid = 1'b0;
        check_idle("abort");
        load_key(16'h1234, 0, ^16'h1234);
        check("reload key_out", {16'd0, key_out}, 32'h1234);
        check("reload armed", {31'd0, key_armed}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // start and clear together: clear wins.
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        check_idle("start+clear");
        step();
        check("start+clear later busy", {31'd0, busy}, 32'd0);

        // start and svalid ignored while ARMED.
        load_key(16'hBEEF, 0, ^16'hBEEF);
        check("beef key_out", {16'd0, key_out}, 32'hBEEF);
        start      = 1'b1;
        key_svalid = 1'b1;
        key_sdata  = 1'b0;
        step();
        start      = 1'b0;
        step();
        key_svalid = 1'b0;
        check("armed start key_out", {16'd0, key_out}, 32'hBEEF);
        check("armed start armed", {31'd0, key_armed}, 32'd1);
        check("armed start busy", {31'd0, busy}, 32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_idle("armed clear");

        // Timeout: stall counter reaches 255 after 255 stalled edges, ERROR one edge later.
        pulse_start();
        repeat (255) step();
        check("pre-timeout err", {31'd0, err}, 32'd0);
        check("pre-timeout busy", {31'd0, busy}, 32'd1);
        step();
        check("timeout err", {31'd0, err}, 32'd1);
        check("timeout busy", {31'd0, busy}, 32'd0);
        check("timeout sready", {31'd0, key_sready}, 32'd0);
        check("timeout key_out", {16'd0, key_out}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("error start err", {31'd0, err}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_idle("error clear");

        // One bit every 200 cycles never times out.
        saw_err = 1'b0;
        pulse_start();
        for (int i = 0; i < NB; i++) begin
            key_svalid = 1'b0;
            for (int g = 0; g < 199; g++) begin
                step();
                if (err) saw_err = 1'b1;
            end
            key_svalid = 1'b1;
            key_sdata  = i < 16 ? 1'((16'hC3A5 >> i) & 16'd1) : ^16'hC3A5;
            step();
            if (err) saw_err = 1'b1;
        end
        key_svalid = 1'b0;
`ifdef RLL_KEY_SEQUENCER_PARITY_EN
        step();
`endif
        check("slow no timeout", {31'd0, saw_err}, 32'd0);
        check("slow armed", {31'd0, key_armed}, 32'd1);
        check("slow key_out", {16'd0, key_out}, 32'hC3A5);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Async reset between edges mid-LOAD.
        pulse_start();
        shift_bits(17'h0001F, 5, 0);
        #3 rst_n = 1'b0;
        #1;
        check_idle("async reset");
        step();
        check_idle("reset held");
        rst_n = 1'b1;
        key_svalid = 1'b1;
        key_sdata  = 1'b1;
        repeat (20) step();
        key_svalid = 1'b0;
        check_idle("after reset idle");
        load_key(16'h0F0F, 0, ^16'h0F0F);
        check("after reset reload", {16'd0, key_out}, 32'h0F0F);
        check("after reset armed", {31'd0, key_armed}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;

`ifdef RLL_KEY_SEQUENCER_PARITY_EN
        load_key(16'h0001, 0, 1'b1);
        check("parity ok armed", {31'd0, key_armed}, 32'd1);
        check("parity ok key_out", {16'd0, key_out}, 32'h0001);
        clear = 1'b1;
        step();
        clear = 1'b0;
        load_key(16'h0001, 0, 1'b0);
        check("parity bad err", {31'd0, err}, 32'd1);
        check("parity bad key_out", {16'd0, key_out}, 32'd0);
        check("parity bad armed", {31'd0, key_armed}, 32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
